// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Holds the FSM state encoding and the next-PC select codes driven by control.
package fetch_unit_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned SRC_W   = 2;

    typedef logic [XLEN-1:0]  word_t;
    typedef logic [SRC_W-1:0] src_pc_t;

    // Fetch sequencing states.
    typedef enum logic [1:0] {
        FETCH = 2'b00,
        EXEC  = 2'b01,
        HALT  = 2'b10
    } state_e;

    // Next-PC select codes from the control unit.
    localparam src_pc_t PC_SEQ  = 2'b00;
    localparam src_pc_t PC_IMM  = 2'b01;
    localparam src_pc_t PC_JALR = 2'b10;
    localparam src_pc_t PC_SYS  = 2'b11;

    localparam word_t PC_STEP  = word_t'(4);
    localparam word_t NOP_INST = 32'h0000_0013;

endpackage

// File: rtl/next_pc_sel.sv
// Combinational next-PC selection for the fetch unit.
// All arithmetic is modulo 2^32; jalr targets have bit 0 cleared.
module next_pc_sel
    import fetch_unit_pkg::*;
(
    input  logic [XLEN-1:0]  pc_i,
    input  logic [XLEN-1:0]  pc_plus4_i,
    input  logic [XLEN-1:0]  imm_i,
    input  logic [XLEN-1:0]  alu_result_i,
    input  logic [SRC_W-1:0] src_pc_i,
    input  logic             branch_i,
    input  logic             jump_i,
    input  logic             br_cond_i,
    output logic [XLEN-1:0]  next_pc_o
);

    logic            take_imm;
    logic [XLEN-1:0] imm_target;
    logic [XLEN-1:0] jalr_target;

    assign take_imm    = jump_i | (branch_i & br_cond_i);
    assign imm_target  = pc_i + imm_i;
    assign jalr_target = alu_result_i & ~word_t'(1);

    always_comb begin
        next_pc_o = pc_plus4_i;
        case (src_pc_i)
            PC_SEQ, PC_SYS: next_pc_o = pc_plus4_i;
            PC_IMM:         next_pc_o = take_imm ? imm_target : pc_plus4_i;
            PC_JALR:        next_pc_o = jalr_target;
            default:        next_pc_o = pc_plus4_i;
        endcase
    end

endmodule

// File: rtl/fetch_unit.sv
// Multi-cycle instruction fetch unit: FETCH -> EXEC -> (FETCH | HALT).
// Owns the PC and latched instruction; next-PC muxing lives in next_pc_sel.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [XLEN-1:0]   imem_addr,
    input  logic              imem_ack,
    input  logic [XLEN-1:0]   imem_rdata,
    output logic [XLEN-1:0]   inst,
    output logic              inst_valid,
    output logic [XLEN-1:0]   pc,
    output logic [XLEN-1:0]   pc_plus4,
    input  logic [SRC_W-1:0]  srcPC,
    input  logic              pcload,
    input  logic              branch,
    input  logic              jump,
    input  logic              br_cond,
    input  logic [XLEN-1:0]   imm,
    input  logic [XLEN-1:0]   alu_result,
    input  logic              resume,
    output logic              halted
);

    state_e          state_q;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] inst_q;
    logic            req_q;
    logic            valid_q;
    logic            halted_q;
    logic [XLEN-1:0] pc_plus4_d;
    logic [XLEN-1:0] next_pc_d;

    assign pc_plus4_d = pc_q + PC_STEP;

    next_pc_sel u_next_pc_sel (
        .pc_i         (pc_q),
        .pc_plus4_i   (pc_plus4_d),
        .imm_i        (imm),
        .alu_result_i (alu_result),
        .src_pc_i     (srcPC),
        .branch_i     (branch),
        .jump_i       (jump),
        .br_cond_i    (br_cond),
        .next_pc_o    (next_pc_d)
    );

    // Sequencer; req/valid/halted are registered alongside the state they decode.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= FETCH;
            pc_q     <= RESET_PC;
            inst_q   <= NOP_INST;
            req_q    <= 1'b1;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            case (state_q)
                FETCH: begin
                    if (imem_ack) begin
                        inst_q  <= imem_rdata;
                        state_q <= EXEC;
                        req_q   <= 1'b0;
                        valid_q <= 1'b1;
                    end
                end
                EXEC: begin
                    valid_q <= 1'b0;
                    if (pcload) begin
                        pc_q    <= next_pc_d;
                        state_q <= FETCH;
                        req_q   <= 1'b1;
                    end else begin
                        state_q  <= HALT;
                        halted_q <= 1'b1;
                    end
                end
                HALT: begin
                    // Resume steps past the ebreak the PC still points at.
                    if (resume) begin
                        pc_q     <= pc_plus4_d;
                        state_q  <= FETCH;
                        req_q    <= 1'b1;
                        halted_q <= 1'b0;
                    end
                end
                default: begin
                    state_q  <= FETCH;
                    req_q    <= 1'b1;
                    valid_q  <= 1'b0;
                    halted_q <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req   = req_q;
    assign imem_addr  = pc_q;
    assign inst       = inst_q;
    assign inst_valid = valid_q;
    assign pc         = pc_q;
    assign pc_plus4   = pc_plus4_d;
    assign halted     = halted_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit: reset, sequential/branch/jalr
// next-PC, PC wrap, halt/resume and reset colliding with an ack.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] inst;
    logic        inst_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [1:0]  srcPC;
    logic        pcload;
    logic        branch;
    logic        jump;
    logic        br_cond;
    logic [31:0] imm;
    logic [31:0] alu_result;
    logic        resume;
    logic        halted;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk        (clk),
        .rst        (rst),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .inst       (inst),
        .inst_valid (inst_valid),
        .pc         (pc),
        .pc_plus4   (pc_plus4),
        .srcPC      (srcPC),
        .pcload     (pcload),
        .branch     (branch),
        .jump       (jump),
        .br_cond    (br_cond),
        .imm        (imm),
        .alu_result (alu_result),
        .resume     (resume),
        .halted     (halted)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic step();
        @(negedge clk);
    endtask

    // From FETCH: return ack with word w for one cycle; leaves the DUT in EXEC.
    task automatic fetch(input logic [31:0] w);
        imem_ack   = 1'b1;
        imem_rdata = w;
        step();
        imem_ack   = 1'b0;
        imem_rdata = 32'hxxxx_xxxx;
    endtask

    // From EXEC: present control for one cycle, then restore idle control.
    task automatic exec(input logic [1:0] s, input logic b, input logic j, input logic c,
                        input logic [31:0] im, input logic [31:0] alu, input logic ld);
        srcPC = s; branch = b; jump = j; br_cond = c; imm = im; alu_result = alu; pcload = ld;
        step();
        srcPC = 2'b00; branch = 1'b0; jump = 1'b0; br_cond = 1'b0;
        imm = 32'h0; alu_result = 32'h0; pcload = 1'b1;
    endtask

    // Jump to an absolute target via jalr (one fetch + one exec).
    task automatic goto(input logic [31:0] target);
        fetch(32'h0000_0067);
        exec(2'b10, 1'b0, 1'b1, 1'b0, 32'h0, target, 1'b1);
    endtask

    initial begin
        rst = 1'b1; imem_ack = 1'b0; imem_rdata = 32'h0; srcPC = 2'b00; pcload = 1'b1;
        branch = 1'b0; jump = 1'b0; br_cond = 1'b0; imm = 32'h0; alu_result = 32'h0;
        resume = 1'b0;
        step(); step();
        rst = 1'b0;

        // Reset state
        check("rst_req", 32'(imem_req), 32'd1);
        check("rst_addr", imem_addr, 32'h0);
        check("rst_pc", pc, 32'h0);
        check("rst_inst", inst, 32'h0000_0013);
        check("rst_valid", 32'(inst_valid), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);

        // Ack withheld 3 cycles: request and address hold
        for (int i = 0; i < 3; i++) begin
            step();
            check("wait_req", 32'(imem_req), 32'd1);
            check("wait_addr", imem_addr, 32'h0);
            check("wait_inst", inst, 32'h0000_0013);
        end
        fetch(32'h0050_0093);
        check("exec_valid", 32'(inst_valid), 32'd1);
        check("exec_inst", inst, 32'h0050_0093);
        check("exec_req", 32'(imem_req), 32'd0);
        check("exec_pc4", pc_plus4, 32'h4);
        exec(2'b00, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        check("seq_valid", 32'(inst_valid), 32'd0);
        check("seq_req", 32'(imem_req), 32'd1);
        check("seq_addr", imem_addr, 32'h4);
        check("seq_pc", pc, 32'h4);

        // jalr clears bit 0
        goto(32'h0000_0101);
        check("jalr_lsb", pc, 32'h100);

        // Branch not taken / taken with imm = -8
        fetch(32'hFE00_0CE3);
        exec(2'b01, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFF8, 32'h0, 1'b1);
        check("br_nt", pc, 32'h104);
        goto(32'h0000_0100);
        fetch(32'hFE00_0CE3);
        exec(2'b01, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFF8, 32'h0, 1'b1);
        check("br_t", pc, 32'hF8);

        // jalr from 0x40 to 0x203 -> 0x202
        goto(32'h0000_0040);
        fetch(32'h0000_0067);
        check("jalr_pc4", pc_plus4, 32'h44);
        exec(2'b10, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0000_0203, 1'b1);
        check("jalr_pc", pc, 32'h202);

        // srcPC=11 is sequential even with jump; srcPC=01 with jump alone
        fetch(32'h0000_0073);
        exec(2'b11, 1'b1, 1'b1, 1'b1, 32'h1000, 32'h0, 1'b1);
        check("sys_seq", pc, 32'h206);
        fetch(32'h0100_006F);
        exec(2'b01, 1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b1);
        check("jal_imm", pc, 32'h216);

        // Wrap at top of address space
        goto(32'hFFFF_FFFC);
        check("wrap_pc4", pc_plus4, 32'h0);
        fetch(32'h0000_0013);
        exec(2'b00, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        check("wrap_pc", pc, 32'h0);

        // Halt at 0x80; stray ack and hold for 10 cycles
        goto(32'h0000_0080);
        fetch(32'h0010_0073);
        exec(2'b00, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
        for (int i = 0; i < 10; i++) begin
            check("halt_halted", 32'(halted), 32'd1);
            check("halt_req", 32'(imem_req), 32'd0);
            check("halt_valid", 32'(inst_valid), 32'd0);
            check("halt_pc", pc, 32'h80);
            step();
        end
        imem_ack = 1'b0;
        check("halt_inst", inst, 32'h0010_0073);
        resume = 1'b1;
        step();
        resume = 1'b0;
        check("resume_pc", pc, 32'h84);
        check("resume_req", 32'(imem_req), 32'd1);
        check("resume_halted", 32'(halted), 32'd0);

        // Resume in FETCH is ignored
        resume = 1'b1;
        step();
        resume = 1'b0;
        check("fetch_resume_pc", pc, 32'h84);
        check("fetch_resume_req", 32'(imem_req), 32'd1);

        // Reset colliding with ack at pc=0x30
        goto(32'h0000_0030);
        check("pre_rst_addr", imem_addr, 32'h30);
        imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF; rst = 1'b1;
        step();
        imem_ack = 1'b0; rst = 1'b0;
        check("rstack_inst", inst, 32'h0000_0013);
        check("rstack_addr", imem_addr, 32'h0);
        check("rstack_valid", 32'(inst_valid), 32'd0);
        check("rstack_req", 32'(imem_req), 32'd1);

        // Reset exits HALT
        fetch(32'h0010_0073);
        exec(2'b00, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        check("pre_rst_halted", 32'(halted), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rsthalt_halted", 32'(halted), 32'd0);
        check("rsthalt_req", 32'(imem_req), 32'd1);
        check("rsthalt_pc", pc, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
